// File: rtl/fetch_queue.sv
// Dual-entry-in, dual-entry-out instruction queue decoupling fetch from dual-issue decode.
// Head and head+1 are read combinationally from registered storage; writes are visible the next cycle.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid_alpha,
    input  logic             in_valid_beta,
    input  logic [31:0]      in_addr_alpha,
    input  logic [31:0]      in_addr_beta,
    input  logic [31:0]      in_instr_alpha,
    input  logic [31:0]      in_instr_beta,
    input  logic             in_inds_alpha,
    input  logic             in_inds_beta,
    input  logic             in_addr_err_alpha,
    input  logic             in_addr_err_beta,
    output logic             in_ready,
    input  logic [1:0]       pop_cnt,
    output logic             out_valid_alpha,
    output logic             out_valid_beta,
    output logic [31:0]      out_addr_alpha,
    output logic [31:0]      out_addr_beta,
    output logic [31:0]      out_instr_alpha,
    output logic [31:0]      out_instr_beta,
    output logic             out_inds_alpha,
    output logic             out_inds_beta,
    output logic             out_addr_err_alpha,
    output logic             out_addr_err_beta,
    output logic [PTR_W:0]   count
);

    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic        inds_mem  [DEPTH];
    logic        err_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;
    logic [1:0]       push_n, pop_eff;
    logic [PTR_W:0]   count_next;

    assign wr_ptr_p1 = wr_ptr_reg + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr_reg + PTR_W'(1);

    // Readiness is judged on the registered count only, so a same-cycle pop never helps a push.
    assign in_ready = (count_reg <= (PTR_W+1)'(DEPTH - 2));

    always_comb begin
        push_n = 2'd0;
        if (in_ready && in_valid_alpha)
            push_n = in_valid_beta ? 2'd2 : 2'd1;
        pop_eff = pop_cnt;
        if ((PTR_W+1)'(pop_cnt) > count_reg)
            pop_eff = count_reg[1:0];
        count_next = count_reg + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                instr_mem[i] <= '0;
                inds_mem[i]  <= 1'b0;
                err_mem[i]   <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_n != 2'd0) begin
                addr_mem[wr_ptr_reg]  <= in_addr_alpha;
                instr_mem[wr_ptr_reg] <= in_instr_alpha;
                inds_mem[wr_ptr_reg]  <= in_inds_alpha;
                err_mem[wr_ptr_reg]   <= in_addr_err_alpha;
            end
            if (push_n == 2'd2) begin
                addr_mem[wr_ptr_p1]  <= in_addr_beta;
                instr_mem[wr_ptr_p1] <= in_instr_beta;
                inds_mem[wr_ptr_p1]  <= in_inds_beta;
                err_mem[wr_ptr_p1]   <= in_addr_err_beta;
            end
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_n);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_eff);
            count_reg  <= count_next;
        end
    end

    assign count           = count_reg;
    assign out_valid_alpha = (count_reg != '0);
    assign out_valid_beta  = (count_reg >= (PTR_W+1)'(2));

    // Invalid lanes read as zero so decode sees a nop rather than stale storage.
    assign out_addr_alpha     = out_valid_alpha ? addr_mem[rd_ptr_reg]  : '0;
    assign out_instr_alpha    = out_valid_alpha ? instr_mem[rd_ptr_reg] : '0;
    assign out_inds_alpha     = out_valid_alpha & inds_mem[rd_ptr_reg];
    assign out_addr_err_alpha = out_valid_alpha & err_mem[rd_ptr_reg];
    assign out_addr_beta      = out_valid_beta ? addr_mem[rd_ptr_p1]  : '0;
    assign out_instr_beta     = out_valid_beta ? instr_mem[rd_ptr_p1] : '0;
    assign out_inds_beta      = out_valid_beta & inds_mem[rd_ptr_p1];
    assign out_addr_err_beta  = out_valid_beta & err_mem[rd_ptr_p1];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        in_valid_alpha, in_valid_beta;
    logic [31:0] in_addr_alpha, in_addr_beta, in_instr_alpha, in_instr_beta;
    logic        in_inds_alpha, in_inds_beta, in_addr_err_alpha, in_addr_err_beta;
    logic        in_ready;
    logic [1:0]  pop_cnt;
    logic        out_valid_alpha, out_valid_beta;
    logic [31:0] out_addr_alpha, out_addr_beta, out_instr_alpha, out_instr_beta;
    logic        out_inds_alpha, out_inds_beta, out_addr_err_alpha, out_addr_err_beta;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid_alpha(in_valid_alpha), .in_valid_beta(in_valid_beta),
        .in_addr_alpha(in_addr_alpha), .in_addr_beta(in_addr_beta),
        .in_instr_alpha(in_instr_alpha), .in_instr_beta(in_instr_beta),
        .in_inds_alpha(in_inds_alpha), .in_inds_beta(in_inds_beta),
        .in_addr_err_alpha(in_addr_err_alpha), .in_addr_err_beta(in_addr_err_beta),
        .in_ready(in_ready), .pop_cnt(pop_cnt),
        .out_valid_alpha(out_valid_alpha), .out_valid_beta(out_valid_beta),
        .out_addr_alpha(out_addr_alpha), .out_addr_beta(out_addr_beta),
        .out_instr_alpha(out_instr_alpha), .out_instr_beta(out_instr_beta),
        .out_inds_alpha(out_inds_alpha), .out_inds_beta(out_inds_beta),
        .out_addr_err_alpha(out_addr_err_alpha), .out_addr_err_beta(out_addr_err_beta),
        .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) assert (pop_cnt != 2'd3) else $error("illegal pop_cnt=3");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic idle();
        flush = 1'b0;
        in_valid_alpha = 1'b0; in_valid_beta = 1'b0;
        in_addr_alpha = '0; in_addr_beta = '0;
        in_instr_alpha = '0; in_instr_beta = '0;
        in_inds_alpha = 1'b0; in_inds_beta = 1'b0;
        in_addr_err_alpha = 1'b0; in_addr_err_beta = 1'b0;
        pop_cnt = 2'd0;
    endtask

    task automatic offer(input logic va, input logic vb, input logic [31:0] pa, input logic [31:0] ia,
                         input logic [31:0] pb, input logic [31:0] ib);
        in_valid_alpha = va; in_valid_beta = vb;
        in_addr_alpha = pa; in_instr_alpha = ia;
        in_addr_beta = pb; in_instr_beta = ib;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          exp_cnt;
    int          popped;
    logic [31:0] next_pc;

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_valid_a", 32'(out_valid_alpha), 32'd0);
        check("rst_valid_b", 32'(out_valid_beta), 32'd0);
        check("rst_addr_a", out_addr_alpha, 32'd0);
        rst = 1'b0;
        tick();

        // Basic pair push
        offer(1, 1, 32'hBFC00000, 32'h24080001, 32'hBFC00004, 32'h24090002);
        tick(); idle();
        check("pair_count", 32'(count), 32'd2);
        check("pair_valid_a", 32'(out_valid_alpha), 32'd1);
        check("pair_valid_b", 32'(out_valid_beta), 32'd1);
        check("pair_addr_a", out_addr_alpha, 32'hBFC00000);
        check("pair_addr_b", out_addr_beta, 32'hBFC00004);
        check("pair_instr_a", out_instr_alpha, 32'h24080001);
        check("pair_instr_b", out_instr_beta, 32'h24090002);
        pop_cnt = 2'd2;
        tick(); idle();
        check("pop2_count", 32'(count), 32'd0);
        check("pop2_valid_a", 32'(out_valid_alpha), 32'd0);
        check("pop2_addr_a", out_addr_alpha, 32'd0);

        // Beta without alpha is ignored
        offer(0, 1, 32'h0, 32'h0, 32'h9000, 32'h1);
        tick(); idle();
        check("beta_only_count", 32'(count), 32'd0);

        // Fill to DEPTH
        for (int k = 0; k < 4; k++) begin
            offer(1, 1, 32'h1000 + 32'(8*k), 32'h100 + 32'(k), 32'h1004 + 32'(8*k), 32'h200 + 32'(k));
            tick(); idle();
            check($sformatf("fill%0d_count", k), 32'(count), 32'(2*(k+1)));
            check($sformatf("fill%0d_ready", k), 32'(in_ready), (k == 3) ? 32'd0 : 32'd1);
        end
        offer(1, 1, 32'hDEAD0000, 32'h0, 32'hDEAD0004, 32'h0);
        tick(); idle();
        check("full_push_ignored", 32'(count), 32'd8);
        check("full_addr_a", out_addr_alpha, 32'h1000);
        check("full_addr_b", out_addr_beta, 32'h1004);
        flush = 1'b1;
        #1;
        check("flush_cycle_valid", 32'(out_valid_alpha), 32'd1);
        tick(); idle();
        check("flush_count", 32'(count), 32'd0);

        // Push 2 / pop 1 per cycle with in-order drain
        exp_cnt = 0; popped = 0; next_pc = 32'h2000;
        for (int c = 0; c < 10; c++) begin
            offer(1, 1, next_pc, 32'h0, next_pc + 32'd4, 32'h0);
            pop_cnt = 2'd1;
            #1;
            check($sformatf("ramp%0d_ready", c), 32'(in_ready), (exp_cnt <= 6) ? 32'd1 : 32'd0);
            if (exp_cnt >= 1) begin
                check($sformatf("ramp%0d_head", c), out_addr_alpha, 32'h2000 + 32'(4*popped));
                popped++;
            end
            if (exp_cnt <= 6) begin
                exp_cnt += 2;
                next_pc += 32'd8;
            end
            if (exp_cnt - 2 >= 1 || (exp_cnt >= 1 && popped > 0)) begin end
            tick(); idle();
            if (c > 0) exp_cnt -= 1;
            check($sformatf("ramp%0d_count", c), 32'(count), 32'(exp_cnt));
        end
        flush = 1'b1;
        tick(); idle();

        // Wrap: wr_ptr at 7, pair straddles 7 -> 0
        for (int k = 0; k < 3; k++) begin
            offer(1, 1, 32'h3000 + 32'(8*k), 32'h0, 32'h3004 + 32'(8*k), 32'h0);
            tick();
        end
        offer(1, 0, 32'h3018, 32'h0, 32'h0, 32'h0);
        tick(); idle();
        check("wrap_fill_count", 32'(count), 32'd7);
        pop_cnt = 2'd2; tick(); tick(); tick();
        pop_cnt = 2'd1; tick(); idle();
        check("wrap_drain_count", 32'(count), 32'd0);
        offer(1, 1, 32'h4000, 32'hA, 32'h4004, 32'hB);
        tick(); idle();
        check("wrap_count", 32'(count), 32'd2);
        check("wrap_addr_a", out_addr_alpha, 32'h4000);
        check("wrap_addr_b", out_addr_beta, 32'h4004);
        check("wrap_instr_b", out_instr_beta, 32'hB);
        pop_cnt = 2'd1;
        tick(); idle();
        check("wrap_slot0_head", out_addr_alpha, 32'h4004);
        check("wrap_pop1_count", 32'(count), 32'd1);
        pop_cnt = 2'd1;
        tick(); idle();

        // Flush at count=5 overrides same-cycle push and pop
        offer(1, 1, 32'h5000, 32'h1, 32'h5004, 32'h2); tick();
        offer(1, 1, 32'h5008, 32'h3, 32'h500C, 32'h4); tick();
        offer(1, 0, 32'h5010, 32'h5, 32'h0, 32'h0); tick(); idle();
        check("pre_flush_count", 32'(count), 32'd5);
        flush = 1'b1; pop_cnt = 2'd2;
        offer(1, 1, 32'h5100, 32'h6, 32'h5104, 32'h7);
        tick(); idle();
        check("flush5_count", 32'(count), 32'd0);
        check("flush5_valid_a", 32'(out_valid_alpha), 32'd0);
        check("flush5_valid_b", 32'(out_valid_beta), 32'd0);
        check("flush5_addr_a", out_addr_alpha, 32'd0);
        check("flush5_instr_b", out_instr_beta, 32'd0);
        check("flush5_ready", 32'(in_ready), 32'd1);
        offer(1, 1, 32'h6000, 32'h0, 32'h6004, 32'h0);
        tick(); idle();
        check("post_flush_head", out_addr_alpha, 32'h6000);
        pop_cnt = 2'd2;
        tick(); idle();

        // Over-pop clamps; flags propagate at head
        offer(1, 0, 32'h7000, 32'h0, 32'h0, 32'h0);
        in_addr_err_alpha = 1'b1; in_inds_alpha = 1'b1;
        tick(); idle();
        check("single_count", 32'(count), 32'd1);
        check("single_valid_b", 32'(out_valid_beta), 32'd0);
        check("single_addr_b", out_addr_beta, 32'd0);
        check("single_err_a", 32'(out_addr_err_alpha), 32'd1);
        check("single_inds_a", 32'(out_inds_alpha), 32'd1);
        pop_cnt = 2'd2;
        tick(); idle();
        check("overpop_count", 32'(count), 32'd0);
        check("overpop_err_a", 32'(out_addr_err_alpha), 32'd0);
        offer(1, 1, 32'h8000, 32'h0, 32'h8004, 32'h0);
        tick(); idle();
        check("after_overpop_count", 32'(count), 32'd2);
        check("after_overpop_head", out_addr_alpha, 32'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
